// File: rtl/sub_pipe.sv
// sub_pipe: pipelined subtractor, DIFF = A - B, with a segmented borrow chain.
//
// The WIDTH-bit subtraction is cut into STAGES segments of SEG = WIDTH/STAGES bits.
// Stage k subtracts segment k using the borrow registered by stage k-1. The last
// stage also applies saturation and computes the flags before the output register.
// Latency is STAGES un-stalled clock edges, and throughput is one operation per cycle.
//
// Ports:
//   Clk       rising-edge clock
//   Rst       asynchronous, active-high reset; clears valid bits and outputs
//   InValid   A/B/SignedOp/Sat valid this cycle (ignored while Stall=1)
//   Stall     freeze every register in the pipeline, including the outputs
//   A, B      minuend, subtrahend
//   SignedOp  1 = two's-complement, 0 = unsigned
//   Sat       1 = saturate on Borrow (unsigned) / Overflow (signed), 0 = wrap
//   OutValid  DIFF and flags are valid
//   DIFF      result after optional saturation
//   Borrow    unsigned A < B
//   Overflow  signed overflow of A - B
//   Zero      DIFF == 0, taken after saturation
module sub_pipe #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    input  logic             Stall,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SignedOp,
    input  logic             Sat,
    output logic             OutValid,
    output logic [WIDTH-1:0] DIFF,
    output logic             Borrow,
    output logic             Overflow,
    output logic             Zero
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned MSB  = WIDTH - 1;
    localparam int unsigned LAST = STAGES - 1;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {MSB{1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {MSB{1'b0}}};

    // Stage inputs: stage 0 sees the ports, stage k>0 sees pipeline register k-1.
    logic [WIDTH-1:0] si_a  [STAGES];
    logic [WIDTH-1:0] si_b  [STAGES];
    logic [WIDTH-1:0] si_r  [STAGES];
    logic             si_bw [STAGES];
    logic             si_sg [STAGES];
    logic             si_st [STAGES];
    logic             si_v  [STAGES];

    // Stage outputs: partial result with segment k filled in, and its borrow-out.
    logic [SEG:0]     seg_d [STAGES];
    logic [WIDTH-1:0] nx_r  [STAGES];
    logic             nx_bw [STAGES];

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            // One extra MSB catches the borrow out of this segment.
            seg_d[k] = {1'b0, si_a[k][k*SEG +: SEG]} - {1'b0, si_b[k][k*SEG +: SEG]}
                       - {{SEG{1'b0}}, si_bw[k]};
            nx_r[k]  = si_r[k];
            nx_r[k][k*SEG +: SEG] = seg_d[k][SEG-1:0];
            nx_bw[k] = seg_d[k][SEG];
        end
    end

    if (STAGES > 1) begin : g_pipe
        logic [WIDTH-1:0] pa_q  [STAGES-1];
        logic [WIDTH-1:0] pb_q  [STAGES-1];
        logic [WIDTH-1:0] pr_q  [STAGES-1];
        logic             pbw_q [STAGES-1];
        logic             psg_q [STAGES-1];
        logic             pst_q [STAGES-1];
        logic             pv_q  [STAGES-1];

        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                for (int k = 0; k < STAGES - 1; k++) begin
                    pa_q[k]  <= '0;
                    pb_q[k]  <= '0;
                    pr_q[k]  <= '0;
                    pbw_q[k] <= 1'b0;
                    psg_q[k] <= 1'b0;
                    pst_q[k] <= 1'b0;
                    pv_q[k]  <= 1'b0;
                end
            end else if (!Stall) begin
                for (int k = 0; k < STAGES - 1; k++) begin
                    pa_q[k]  <= si_a[k];
                    pb_q[k]  <= si_b[k];
                    pr_q[k]  <= nx_r[k];
                    pbw_q[k] <= nx_bw[k];
                    psg_q[k] <= si_sg[k];
                    pst_q[k] <= si_st[k];
                    pv_q[k]  <= si_v[k];
                end
            end
        end

        always_comb begin
            si_a[0]  = A;
            si_b[0]  = B;
            si_r[0]  = '0;
            si_bw[0] = 1'b0;
            si_sg[0] = SignedOp;
            si_st[0] = Sat;
            si_v[0]  = InValid;
            for (int k = 1; k < STAGES; k++) begin
                si_a[k]  = pa_q[k-1];
                si_b[k]  = pb_q[k-1];
                si_r[k]  = pr_q[k-1];
                si_bw[k] = pbw_q[k-1];
                si_sg[k] = psg_q[k-1];
                si_st[k] = pst_q[k-1];
                si_v[k]  = pv_q[k-1];
            end
        end
    end else begin : g_flat
        always_comb begin
            si_a[0]  = A;
            si_b[0]  = B;
            si_r[0]  = '0;
            si_bw[0] = 1'b0;
            si_sg[0] = SignedOp;
            si_st[0] = Sat;
            si_v[0]  = InValid;
        end
    end

    // Final stage: flags from the raw result, then optional saturation.
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] fin_d;
    logic             fin_bw;
    logic             fin_ov;

    always_comb begin
        raw    = nx_r[LAST];
        fin_bw = nx_bw[LAST];
        // Signed overflow: operand signs differ and the result sign differs from A.
        fin_ov = (si_a[LAST][MSB] != si_b[LAST][MSB]) && (raw[MSB] != si_a[LAST][MSB]);
        fin_d  = raw;
        if (si_st[LAST]) begin
            if (!si_sg[LAST] && fin_bw) begin
                fin_d = '0;
            end else if (si_sg[LAST] && fin_ov) begin
                fin_d = si_a[LAST][MSB] ? SMIN : SMAX;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            OutValid <= 1'b0;
            DIFF     <= '0;
            Borrow   <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
        end else if (!Stall) begin
            OutValid <= si_v[LAST];
            DIFF     <= fin_d;
            Borrow   <= fin_bw;
            Overflow <= fin_ov;
            Zero     <= (fin_d == '0);
        end
    end

endmodule

// File: tb/tb_sub_pipe.sv
// Self-checking bench for sub_pipe: an 8-bit/2-stage instance for directed vectors and
// corner sequences, and three 64-bit instances (1, 4 and 64 stages) for a random sweep
// against a reference model. Expected results are queued at drive time and popped when
// the matching DUT presents OutValid on an un-stalled edge.
module tb_sub_pipe;

    typedef struct packed {
        logic [63:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sg;
        logic       st;
        logic [7:0] d;
        logic       bo;
        logic       ov;
        logic       z;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int errors = 0;
    int checks = 0;

    exp_t q8[$];
    exp_t q1[$];
    exp_t q4[$];
    exp_t q64[$];

    // 8-bit, 2-stage instance
    logic       iv8, stall8, sg8, st8;
    logic [7:0] a8, b8;
    logic       v8, bo8, of8, z8;
    logic [7:0] d8;

    sub_pipe #(.WIDTH(8), .STAGES(2)) u_d8 (
        .Clk(clk), .Rst(rst), .InValid(iv8), .Stall(stall8), .A(a8), .B(b8),
        .SignedOp(sg8), .Sat(st8), .OutValid(v8), .DIFF(d8), .Borrow(bo8),
        .Overflow(of8), .Zero(z8)
    );

    // 64-bit instances share one stimulus stream
    logic        iv64, stall64, sg64, st64;
    logic [63:0] a64, b64;
    logic        v1, bo1, of1, z1;
    logic        v4, bo4, of4, z4;
    logic        v64, bo64, of64, z64;
    logic [63:0] d1, d4, d64;

    sub_pipe #(.WIDTH(64), .STAGES(1)) u_s1 (
        .Clk(clk), .Rst(rst), .InValid(iv64), .Stall(stall64), .A(a64), .B(b64),
        .SignedOp(sg64), .Sat(st64), .OutValid(v1), .DIFF(d1), .Borrow(bo1),
        .Overflow(of1), .Zero(z1)
    );
    sub_pipe #(.WIDTH(64), .STAGES(4)) u_s4 (
        .Clk(clk), .Rst(rst), .InValid(iv64), .Stall(stall64), .A(a64), .B(b64),
        .SignedOp(sg64), .Sat(st64), .OutValid(v4), .DIFF(d4), .Borrow(bo4),
        .Overflow(of4), .Zero(z4)
    );
    sub_pipe #(.WIDTH(64), .STAGES(64)) u_s64 (
        .Clk(clk), .Rst(rst), .InValid(iv64), .Stall(stall64), .A(a64), .B(b64),
        .SignedOp(sg64), .Sat(st64), .OutValid(v64), .DIFF(d64), .Borrow(bo64),
        .Overflow(of64), .Zero(z64)
    );

    task automatic check(input string nm, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got d=%h b=%b o=%b z=%b, want d=%h b=%b o=%b z=%b",
                     nm, act.d, act.bo, act.ov, act.z, exp.d, exp.bo, exp.ov, exp.z);
        end
    endtask

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic extra(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: OutValid with no pending operation, got 1 want 0", nm);
    endtask

    // Reference: arithmetic on sign-extended 66-bit values, independent of the MSB rule.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input int w, input logic sg, input logic st);
        exp_t m;
        logic [63:0] mask, am, bm, raw;
        logic signed [65:0] sa, sb, sd, smax, smin;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        bm   = b & mask;
        sa   = $signed({2'b00, am} << (66 - w)) >>> (66 - w);
        sb   = $signed({2'b00, bm} << (66 - w)) >>> (66 - w);
        sd   = sa - sb;
        smax = (66'sd1 <<< (w - 1)) - 66'sd1;
        smin = -(66'sd1 <<< (w - 1));
        m.bo = (am < bm);
        m.ov = (sd > smax) || (sd < smin);
        raw  = (am - bm) & mask;
        m.d  = raw;
        if (st && !sg && m.bo) m.d = 64'd0;
        else if (st && sg && m.ov) m.d = ((sd > smax) ? smax[63:0] : smin[63:0]) & mask;
        m.z  = (m.d == 64'd0);
        return m;
    endfunction

    always @(posedge clk) begin : mon8
        logic adv;
        adv = !stall8 && !rst;
        #1;
        if (adv && v8) begin
            if (q8.size() == 0) extra("w8 extra");
            else check("w8 out", exp_t'{d: {56'd0, d8}, bo: bo8, ov: of8, z: z8}, q8.pop_front());
        end
    end

    always @(posedge clk) begin : mon1
        logic adv;
        adv = !stall64 && !rst;
        #1;
        if (adv && v1) begin
            if (q1.size() == 0) extra("s1 extra");
            else check("s1 out", exp_t'{d: d1, bo: bo1, ov: of1, z: z1}, q1.pop_front());
        end
    end

    always @(posedge clk) begin : mon4
        logic adv;
        adv = !stall64 && !rst;
        #1;
        if (adv && v4) begin
            if (q4.size() == 0) extra("s4 extra");
            else check("s4 out", exp_t'{d: d4, bo: bo4, ov: of4, z: z4}, q4.pop_front());
        end
    end

    always @(posedge clk) begin : mon64
        logic adv;
        adv = !stall64 && !rst;
        #1;
        if (adv && v64) begin
            if (q64.size() == 0) extra("s64 extra");
            else check("s64 out", exp_t'{d: d64, bo: bo64, ov: of64, z: z64}, q64.pop_front());
        end
    end

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic sg,
                          input logic st, input exp_t e);
        @(negedge clk);
        iv8 = 1'b1;
        a8  = a;
        b8  = b;
        sg8 = sg;
        st8 = st;
        q8.push_back(e);
    endtask

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    vec_t tv[11];
    logic [63:0] ca[6];
    logic [63:0] cb[6];

    initial begin
        rst = 1'b1;
        iv8 = 1'b0; stall8 = 1'b0; sg8 = 1'b0; st8 = 1'b0; a8 = '0; b8 = '0;
        iv64 = 1'b0; stall64 = 1'b0; sg64 = 1'b0; st64 = 1'b0; a64 = '0; b64 = '0;

        //         a      b      sg    st    d      bo    ov    z
        tv[0]  = '{8'h50, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{8'h10, 8'h01, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{8'h10, 8'h20, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0};
        tv[3]  = '{8'h10, 8'h20, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        tv[4]  = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{8'h7F, 8'hFF, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
        tv[7]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        tv[8]  = '{8'h80, 8'h7F, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
        tv[9]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        tv[10] = '{8'h00, 8'h80, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};

        ca[0] = 64'd0;                  cb[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        ca[1] = 64'h1234_5678_9ABC_DEF0; cb[1] = 64'h1234_5678_9ABC_DEF0;
        ca[2] = 64'h8000_0000_0000_0000; cb[2] = 64'd1;
        ca[3] = 64'h7FFF_FFFF_FFFF_FFFF; cb[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        ca[4] = 64'h8000_0000_0000_0000; cb[4] = 64'h7FFF_FFFF_FFFF_FFFF;
        ca[5] = 64'h0000_0001_0000_0000; cb[5] = 64'd1;

        // Reset state
        @(negedge clk);
        cmp("reset w8", 64'({v8, d8, bo8, of8, z8}), 64'd0);
        cmp("reset s4", 64'({v4, bo4, of4, z4}), 64'd0);
        cmp("reset s4 diff", d4, 64'd0);
        rst = 1'b0;

        // Directed table, streamed back to back
        for (int i = 0; i < 11; i++) begin
            drive8(tv[i].a, tv[i].b, tv[i].sg, tv[i].st,
                   exp_t'{d: {56'd0, tv[i].d}, bo: tv[i].bo, ov: tv[i].ov, z: tv[i].z});
        end
        @(negedge clk);
        iv8 = 1'b0;
        repeat (4) @(negedge clk);
        cmp("table drained", 64'(q8.size()), 64'd0);

        // Streaming with a two-cycle stall after the second op
        drive8(8'd5, 8'd3, 1'b0, 1'b0, exp_t'{d: 64'h02, bo: 1'b0, ov: 1'b0, z: 1'b0});
        drive8(8'd9, 8'd9, 1'b0, 1'b0, exp_t'{d: 64'h00, bo: 1'b0, ov: 1'b0, z: 1'b1});
        @(negedge clk);
        stall8 = 1'b1;
        iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h11;  // offered during stall, must be dropped
        @(negedge clk);
        cmp("stall hold 1", 64'({v8, d8, bo8, of8, z8}), 64'({1'b1, 8'h02, 3'b000}));
        @(negedge clk);
        cmp("stall hold 2", 64'({v8, d8, bo8, of8, z8}), 64'({1'b1, 8'h02, 3'b000}));
        stall8 = 1'b0;
        iv8 = 1'b1; a8 = 8'd0; b8 = 8'd1; sg8 = 1'b0; st8 = 1'b0;
        q8.push_back(exp_t'{d: 64'hFF, bo: 1'b1, ov: 1'b0, z: 1'b0});
        @(negedge clk);
        iv8 = 1'b0;
        repeat (4) @(negedge clk);
        cmp("stream drained", 64'(q8.size()), 64'd0);

        // Asynchronous reset with ops in flight
        drive8(8'h10, 8'h20, 1'b0, 1'b0, exp_t'{d: 64'hF0, bo: 1'b1, ov: 1'b0, z: 1'b0});
        drive8(8'h07, 8'h02, 1'b0, 1'b0, exp_t'{d: 64'h05, bo: 1'b0, ov: 1'b0, z: 1'b0});
        @(negedge clk);
        iv8 = 1'b0;
        cmp("pre-reset out", 64'({v8, d8, bo8}), 64'({1'b1, 8'hF0, 1'b1}));
        #2;
        rst = 1'b1;
        #1;
        cmp("async reset", 64'({v8, d8, bo8, of8, z8}), 64'd0);
        q8.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmp("no ghost after reset", 64'(v8), 64'd0);
        end
        drive8(8'h33, 8'h11, 1'b0, 1'b0, exp_t'{d: 64'h22, bo: 1'b0, ov: 1'b0, z: 1'b0});
        @(negedge clk);
        iv8 = 1'b0;
        cmp("latency edge 1", 64'(v8), 64'd0);
        @(negedge clk);
        cmp("latency edge 2", 64'({v8, d8}), 64'({1'b1, 8'h22}));
        repeat (2) @(negedge clk);

        // Random sweep across 64-bit instances with sporadic stalls
        for (int n = 0; n < 1000; ) begin
            @(negedge clk);
            iv64    = 1'b1;
            stall64 = ($urandom_range(0, 9) == 0);
            sg64    = 1'($urandom_range(0, 1));
            st64    = 1'($urandom_range(0, 1));
            if (n < 6) begin
                a64 = ca[n];
                b64 = cb[n];
            end else begin
                a64 = rnd_val();
                b64 = ($urandom_range(0, 7) == 0) ? a64 : rnd_val();
            end
            if (!stall64) begin
                q1.push_back(model(a64, b64, 64, sg64, st64));
                q4.push_back(model(a64, b64, 64, sg64, st64));
                q64.push_back(model(a64, b64, 64, sg64, st64));
                n++;
            end
        end
        @(negedge clk);
        iv64 = 1'b0;
        stall64 = 1'b0;
        repeat (70) @(negedge clk);
        cmp("s1 drained", 64'(q1.size()), 64'd0);
        cmp("s4 drained", 64'(q4.size()), 64'd0);
        cmp("s64 drained", 64'(q64.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sub_pipe.md
Name: sub_pipe

Overview:
- Parametrised, pipelined successor to the combinational subtractor: computes DIFF = A - B.
- The borrow chain is split into STAGES registered segments so wide subtractions close timing.
- Each operation carries its own signed/unsigned and wrap/saturate mode, plus Borrow/Overflow/Zero flags.
- Streams one operation per cycle with valid/stall control; sits in the datapath library beside the other arithmetic components.

Parameters:
- WIDTH, 64, operand and result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline segments and latency in cycles; 1 <= STAGES <= WIDTH. Segment width SEG = WIDTH/STAGES.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset.
- InValid  input  1  A, B, SignedOp and Sat are valid this cycle.
- Stall  input  1  freeze the whole pipeline; InValid is ignored while high.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- SignedOp  input  1  1 = two's-complement operation, 0 = unsigned.
- Sat  input  1  1 = saturate on Borrow (unsigned) or Overflow (signed), 0 = wrap.
- OutValid  output  1  DIFF and flags are valid.
- DIFF  output  WIDTH  result.
- Borrow  output  1  unsigned A < B, meaningful in both modes.
- Overflow  output  1  signed overflow of A - B, meaningful in both modes.
- Zero  output  1  final DIFF == 0, evaluated after saturation.

Behaviour:
- Reset, asynchronous: all stage valid bits, OutValid, DIFF, Borrow, Overflow and Zero clear to 0 immediately. Operations in flight are discarded, with no partial output.
- Advance: when Stall=0, every stage register loads from its predecessor on each Clk edge. Stage 0 captures InValid together with the operand and mode fields.
- Stall=1: every register holds, including the output registers. OutValid therefore stays at its previous value, and the bench must not count a held output twice. The input sampled during a stall is lost.
- Stage k (0..STAGES-1):
  - computes segment k, bits [k*SEG +: SEG] = A_seg - B_seg - borrow_in, with borrow_in = 0 for k=0;
  - registers the segment result and its borrow_out;
  - passes the upper unprocessed operand bits, the already-computed lower result bits, SignedOp, Sat and valid forward.
- The final stage also produces:
  - Borrow = borrow_out of the top segment;
  - Overflow = (A[MSB] != B[MSB]) && (raw[MSB] != A[MSB]), so the operand MSBs must be carried to the last stage.
- Saturation and flags are applied combinationally in the last stage, before the output register:
  - Sat=1, SignedOp=0, Borrow=1: DIFF = 0.
  - Sat=1, SignedOp=1, Overflow=1: DIFF = 0x7F..F if A[MSB]=0, 0x80..0 if A[MSB]=1.
  - Otherwise DIFF = raw, wrapped modulo 2^WIDTH.
  - Flags report the raw operation even when saturated.
- Latency: a result appears exactly STAGES un-stalled Clk edges after capture. Throughput is 1 op/cycle, with no bubbles between back-to-back operations.
- Invalid slots: result and flag registers still update with don't-care data, but OutValid=0.
- Simultaneous InValid and Stall: Stall wins and the op is not captured.
- STAGES=1: a single registered full-width subtract with latency 1.

Test Plan:
- WIDTH=8, STAGES=2, unsigned wrap: A=0x50, B=0x20 -> after 2 cycles OutValid=1, DIFF=0x30, Borrow=0, Overflow=0, Zero=0.
- Cross-segment borrow: A=0x10, B=0x01 -> DIFF=0x0F, Borrow=0. Then A=0x10, B=0x20 with Sat=0 -> DIFF=0xF0, Borrow=1. Same op with Sat=1 -> DIFF=0x00, Zero=1, Borrow=1.
- Signed saturation:
  - A=0x80, B=0x01 -> Sat=0: DIFF=0x7F, Overflow=1; Sat=1: DIFF=0x80.
  - A=0x7F, B=0xFF -> Sat=1: DIFF=0x7F, Overflow=1.
- Streaming plus stall: ops (5-3), (9-9), (0-1) on consecutive cycles, with Stall=1 for 2 cycles after the 2nd input.
  - Expected outputs in order: 0x02, then 0x00 with Zero=1, then 0xFF with Borrow=1.
  - No ops are lost or duplicated, and the output holds during the stall.
- Reset mid-operation: assert Rst asynchronously between Clk edges while 2 ops are in flight. All outputs go to 0 at once, and no OutValid follows after release. A new op then completes with full latency.
- Parameter sweep: WIDTH=64 with STAGES in {1, 4, 64}, 1000 random ops with random SignedOp/Sat. Compare every output against a reference model, including the cases A=B, A=0 with B=max, and signed min/max corners.
